// File: rtl/adc_serial_rx.sv
// adc_serial_rx
//   Multi-lane serial ADC capture engine. Issues a CONV pulse, then runs SCK
//   while deserialising NCH SDO lanes. Each lane carries NWORDS words per
//   conversion. Samples are stored left-justified as 16-bit words in an
//   internal first-word-fall-through FIFO.
//
//   Optional feature: define ADC_RX_TSTAMP_EN to prepend a 16-bit clk_i cycle
//   timestamp word to every frame. The timestamp is latched on the first CONV
//   cycle.
//
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   start_i  one-cycle conversion request
//   clr_i    synchronous clear: flush FIFO, clear ovf_o, abort frame
//   sdo_i    NCH serial data lanes, MSB first
//   conv_o   ADC convert strobe
//   sck_o    ADC serial clock
//   rd_i     pop FIFO head
//   dat_o    FIFO head word (0 while empty)
//   empty_o  FIFO empty
//   count_o  FIFO occupancy
//   busy_o   frame in progress
//   ovf_o    sticky frame-dropped flag
module adc_serial_rx #(
    parameter int NCH       = 2,
    parameter int NBITS     = 14,
    parameter int NWORDS    = 2,
    parameter int LEAD      = 2,
    parameter int WORDLEN   = 16,
    parameter int SCKDIV    = 2,
    parameter int TCONV     = 4,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 clr_i,
    input  logic [NCH-1:0]       sdo_i,
    output logic                 conv_o,
    output logic                 sck_o,
    input  logic                 rd_i,
    output logic [15:0]          dat_o,
    output logic                 empty_o,
    output logic [DEPTH_LOG:0]   count_o,
    output logic                 busy_o,
    output logic                 ovf_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int CW    = $clog2(TCONV) + 1;
    localparam int DW    = $clog2(2 * SCKDIV) + 1;
    localparam int PW    = $clog2(WORDLEN) + 1;
    localparam int WW    = $clog2(NWORDS) + 1;
    localparam int LW    = $clog2(NCH + 1) + 1;

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, PUSH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        ccnt_q, ccnt_d;
    logic [DW-1:0]        dcnt_q, dcnt_d;
    logic [PW-1:0]        pcnt_q, pcnt_d;
    logic [WW-1:0]        widx_q, widx_d;
    logic [LW-1:0]        lcnt_q, lcnt_d;
    logic                 ovf_q, ovf_d;

    logic [NBITS-1:0]     sr_q [NCH];
    logic                 sample;
    logic                 push;
    logic [15:0]          push_word;

    logic [15:0]          mem [DEPTH];
    logic [DEPTH_LOG-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG:0]   count_q;
    logic                 pop;
    logic [DEPTH_LOG:0]   free_w;
    logic                 room;

`ifdef ADC_RX_TSTAMP_EN
    localparam int TS_WORDS = 1;
    logic [15:0] tcnt_q;
    logic [15:0] ts_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
            ts_q   <= '0;
        end else begin
            tcnt_q <= tcnt_q + 16'd1;
            if (state_q == CONV && ccnt_q == '0)
                ts_q <= tcnt_q;
        end
    end
`else
    localparam int TS_WORDS = 0;
    logic [15:0] ts_q;
    assign ts_q = '0;
`endif

    localparam int FRAME = NCH * NWORDS + TS_WORDS;

    // Space for the whole frame is reserved at start, so pushes never overflow.
    assign free_w = (DEPTH_LOG + 1)'(DEPTH) - count_q;
    assign room   = 32'(free_w) >= FRAME;

    // The timestamp occupies slot 0 of the first PUSH phase only.
    logic             ts_slot;
    logic [LW-1:0]    ts_off;
    logic [LW-1:0]    lane_idx;
    logic             last_slot;

    assign ts_slot   = (TS_WORDS != 0) && (widx_q == '0);
    assign ts_off    = ts_slot ? LW'(1) : '0;
    assign lane_idx  = lcnt_q - ts_off;
    assign last_slot = (lcnt_q == LW'(NCH - 1) + ts_off);

    always_comb begin
        state_d   = state_q;
        ccnt_d    = ccnt_q;
        dcnt_d    = dcnt_q;
        pcnt_d    = pcnt_q;
        widx_d    = widx_q;
        lcnt_d    = lcnt_q;
        ovf_d     = ovf_q;
        sample    = 1'b0;
        push      = 1'b0;
        push_word = '0;

        if (clr_i) begin
            state_d = IDLE;
            ovf_d   = 1'b0;
            ccnt_d  = '0;
            dcnt_d  = '0;
            pcnt_d  = '0;
            widx_d  = '0;
            lcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (room) begin
                            state_d = CONV;
                            ccnt_d  = '0;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (ccnt_q == CW'(TCONV - 1)) begin
                        state_d = SHIFT;
                        dcnt_d  = '0;
                        pcnt_d  = '0;
                        widx_d  = '0;
                    end else begin
                        ccnt_d = ccnt_q + CW'(1);
                    end
                end
                SHIFT: begin
                    // Capture on the high-to-low SCK transition. Only the data
                    // window of each word is captured.
                    sample = (dcnt_q == DW'(SCKDIV - 1)) &&
                             (32'(pcnt_q) >= LEAD) &&
                             (32'(pcnt_q) < LEAD + NBITS);
                    if (dcnt_q == DW'(2 * SCKDIV - 1)) begin
                        dcnt_d = '0;
                        if (pcnt_q == PW'(WORDLEN - 1)) begin
                            state_d = PUSH;
                            lcnt_d  = '0;
                        end else begin
                            pcnt_d = pcnt_q + PW'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                PUSH: begin
                    push = 1'b1;
                    if (ts_slot && lcnt_q == '0) begin
                        push_word = ts_q;
                    end else begin
                        for (int unsigned i = 0; i < NCH; i++) begin
                            if (32'(lane_idx) == i)
                                push_word = 16'(sr_q[i]) << (16 - NBITS);
                        end
                    end
                    if (last_slot) begin
                        if (widx_q == WW'(NWORDS - 1)) begin
                            state_d = IDLE;
                        end else begin
                            state_d = SHIFT;
                            widx_d  = widx_q + WW'(1);
                            pcnt_d  = '0;
                            dcnt_d  = '0;
                        end
                    end else begin
                        lcnt_d = lcnt_q + LW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ccnt_q  <= '0;
            dcnt_q  <= '0;
            pcnt_q  <= '0;
            widx_q  <= '0;
            lcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            dcnt_q  <= dcnt_d;
            pcnt_q  <= pcnt_d;
            widx_q  <= widx_d;
            lcnt_q  <= lcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NCH; i++)
                sr_q[i] <= '0;
        end else if (sample) begin
            for (int unsigned i = 0; i < NCH; i++)
                sr_q[i] <= {sr_q[i][NBITS-2:0], sdo_i[i]};
        end
    end

    assign pop = rd_i && (count_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wptr_q <= wptr_q + DEPTH_LOG'(1);
            if (pop)
                rptr_q <= rptr_q + DEPTH_LOG'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (DEPTH_LOG + 1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_LOG + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wptr_q] <= push_word;
    end

    assign dat_o   = (count_q == '0) ? '0 : mem[rptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign conv_o  = (state_q == CONV);
    assign sck_o   = (state_q == SHIFT) && (dcnt_q < DW'(SCKDIV));
    assign busy_o  = (state_q != IDLE);
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
module tb_adc_serial_rx;

    localparam int NCH       = 2;
    localparam int NBITS     = 14;
    localparam int NWORDS    = 2;
    localparam int LEAD      = 2;
    localparam int WORDLEN   = 16;
    localparam int SCKDIV    = 2;
    localparam int TCONV     = 4;
    localparam int DEPTH_LOG = 4;
`ifdef ADC_RX_TSTAMP_EN
    localparam int TSW = 1;
`else
    localparam int TSW = 0;
`endif
    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int FRAME = NCH * NWORDS + TSW;
    // Frame length in clk_i cycles, from the first CONV cycle to the last PUSH cycle.
    localparam int FLEN  = TCONV + NWORDS * WORDLEN * 2 * SCKDIV + NWORDS * NCH + TSW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 clr = 1'b0;
    logic                 rd = 1'b0;
    logic [NCH-1:0]       sdo = '0;
    logic                 conv_o, sck_o, empty_o, busy_o, ovf_o;
    logic [15:0]          dat_o;
    logic [DEPTH_LOG:0]   count_o;

    adc_serial_rx #(
        .NCH(NCH), .NBITS(NBITS), .NWORDS(NWORDS), .LEAD(LEAD),
        .WORDLEN(WORDLEN), .SCKDIV(SCKDIV), .TCONV(TCONV), .DEPTH_LOG(DEPTH_LOG)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .sdo_i(sdo),
        .conv_o(conv_o), .sck_o(sck_o), .rd_i(rd), .dat_o(dat_o),
        .empty_o(empty_o), .count_o(count_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    int unsigned cyc = 0;
    logic [15:0] tcyc = '0;

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            cyc++;
            tcyc++;
        end
    end

    // ADC behavioural model. It presents the next bit after each SCK rising edge
    // and counts CONV cycles, SCK periods and malformed high phases.
    logic [15:0] adc_d [NWORDS][NCH];
    int unsigned conv_cnt = 0;
    int unsigned rise_cnt = 0;
    int unsigned hi_bad   = 0;

    initial begin
        int w, p, run;
        logic prev;
        w = 0; p = 0; run = 0; prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (conv_o) begin
                conv_cnt++;
                w = 0;
                p = 0;
            end
            if (sck_o && !prev) begin
                rise_cnt++;
                for (int l = 0; l < NCH; l++) begin
                    if (w < NWORDS && p >= LEAD && p < LEAD + NBITS)
                        sdo[l] = adc_d[w][l][NBITS-1-(p-LEAD)];
                    else
                        sdo[l] = 1'($urandom);
                end
                p++;
                if (p == WORDLEN) begin
                    p = 0;
                    w++;
                end
            end
            if (sck_o) begin
                run++;
            end else begin
                if (prev && run != SCKDIV)
                    hi_bad++;
                run = 0;
            end
            prev = sck_o;
        end
    end

    // Reference model: the expected FIFO contents, in order, and the frame timing.
    logic [15:0] exp_q[$];
    logic        ovf_m = 1'b0;
    int unsigned busy_end = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        logic busy_now, acc;
        busy_now = cyc < busy_end;
        acc = (DEPTH - int'(exp_q.size())) >= FRAME;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!busy_now) begin
            if (acc) begin
                busy_end = cyc + FLEN;
                if (TSW != 0)
                    exp_q.push_back(tcyc);
                for (int w = 0; w < NWORDS; w++)
                    for (int l = 0; l < NCH; l++)
                        exp_q.push_back(16'(adc_d[w][l] << (16 - NBITS)));
                chk("busy_after_start", 32'(busy_o), 32'd1);
                chk("conv_after_start", 32'(conv_o), 32'd1);
            end else begin
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input string nm);
        while (cyc < busy_end)
            tick();
        chk({nm, "_busy"}, 32'(busy_o), 32'd0);
        chk({nm, "_count"}, 32'(count_o), 32'(exp_q.size()));
        chk({nm, "_ovf"}, 32'(ovf_o), 32'(ovf_m));
    endtask

    task automatic drain(input string nm);
        while (exp_q.size() > 0) begin
            chk({nm, "_notempty"}, 32'(empty_o), 32'd0);
            chk({nm, "_word"}, 32'(dat_o), 32'(exp_q[0]));
            rd = 1'b1;
            tick();
            rd = 1'b0;
            void'(exp_q.pop_front());
        end
        chk({nm, "_empty"}, 32'(empty_o), 32'd1);
        chk({nm, "_count0"}, 32'(count_o), 32'd0);
    endtask

    task automatic do_clr(input string nm);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        busy_end = cyc;
        chk({nm, "_count"}, 32'(count_o), 32'd0);
        chk({nm, "_empty"}, 32'(empty_o), 32'd1);
        chk({nm, "_ovf"}, 32'(ovf_o), 32'd0);
        chk({nm, "_busy"}, 32'(busy_o), 32'd0);
        chk({nm, "_sck"}, 32'(sck_o), 32'd0);
        chk({nm, "_conv"}, 32'(conv_o), 32'd0);
    endtask

    task automatic rand_data();
        for (int w = 0; w < NWORDS; w++)
            for (int l = 0; l < NCH; l++)
                adc_d[w][l] = 16'($urandom_range(0, (1 << NBITS) - 1));
    endtask

    typedef struct {
        logic [15:0] l0i, l0q, l1i, l1q;
        logic [15:0] e [4];
    } vec_t;

    vec_t tbl [3];
    logic [15:0] got[$];

    initial begin
        int unsigned c0, r0, h0, maxc;

        tbl[0].l0i = 16'h048d; tbl[0].l0q = 16'h08d1; tbl[0].l1i = 16'h0d15; tbl[0].l1q = 16'h1159;
        tbl[0].e[0] = 16'h1234; tbl[0].e[1] = 16'h3454; tbl[0].e[2] = 16'h2344; tbl[0].e[3] = 16'h4564;
        tbl[1].l0i = 16'h3fff; tbl[1].l0q = 16'h0000; tbl[1].l1i = 16'h2aaa; tbl[1].l1q = 16'h1555;
        tbl[1].e[0] = 16'hfffc; tbl[1].e[1] = 16'haaa8; tbl[1].e[2] = 16'h0000; tbl[1].e[3] = 16'h5554;
        tbl[2].l0i = 16'h0001; tbl[2].l0q = 16'h2000; tbl[2].l1i = 16'h0003; tbl[2].l1q = 16'h1fff;
        tbl[2].e[0] = 16'h0004; tbl[2].e[1] = 16'h000c; tbl[2].e[2] = 16'h8000; tbl[2].e[3] = 16'h7ffc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_conv", 32'(conv_o), 32'd0);
        chk("rst_sck", 32'(sck_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_dat", 32'(dat_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven frames with hand-computed words
        for (int i = 0; i < 3; i++) begin
            adc_d[0][0] = tbl[i].l0i; adc_d[1][0] = tbl[i].l0q;
            adc_d[0][1] = tbl[i].l1i; adc_d[1][1] = tbl[i].l1q;
            c0 = conv_cnt; r0 = rise_cnt; h0 = hi_bad;
            do_start();
            if (i == 0) begin
                // A second request while busy must be ignored
                repeat (20) tick();
                do_start();
            end
            wait_done("tbl");
            chk("tbl_conv_cycles", conv_cnt - c0, 32'(TCONV));
            chk("tbl_sck_periods", rise_cnt - r0, 32'(NWORDS * WORDLEN));
            chk("tbl_sck_high", hi_bad - h0, 32'd0);
            chk("tbl_count", 32'(count_o), 32'(FRAME));
            if (TSW != 0) begin
                chk("tbl_ts", 32'(dat_o), 32'(exp_q[0]));
                rd = 1'b1; tick(); rd = 1'b0;
                void'(exp_q.pop_front());
            end
            for (int k = 0; k < 4; k++) begin
                chk("tbl_notempty", 32'(empty_o), 32'd0);
                chk("tbl_word", 32'(dat_o), 32'(tbl[i].e[k]));
                rd = 1'b1; tick(); rd = 1'b0;
                void'(exp_q.pop_front());
            end
            chk("tbl_empty", 32'(empty_o), 32'd1);
        end

        // Fill the FIFO, then a dropped start
        for (int f = 0; f < DEPTH / FRAME; f++) begin
            rand_data();
            do_start();
            wait_done("fill");
        end
        chk("fill_count", 32'(count_o), 32'((DEPTH / FRAME) * FRAME));
        c0 = conv_cnt;
        do_start();
        repeat (10) tick();
        chk("drop_noconv", conv_cnt - c0, 32'd0);
        chk("drop_ovf", 32'(ovf_o), 32'd1);
        chk("drop_busy", 32'(busy_o), 32'd0);
        chk("drop_count", 32'(count_o), 32'((DEPTH / FRAME) * FRAME));
        do_clr("clr_full");

        // Pop every cycle while a frame pushes
        rand_data();
        rd = 1'b1;
        got.delete();
        maxc = 0;
        do_start();
        for (int n = 0; n < FLEN + 8; n++) begin
            if (32'(count_o) > maxc)
                maxc = 32'(count_o);
            if (!empty_o)
                got.push_back(dat_o);
            tick();
        end
        rd = 1'b0;
        chk("stream_maxcount", maxc, 32'd1);
        chk("stream_nwords", 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < FRAME; k++)
            chk("stream_word", 32'(k < got.size() ? got[k] : 16'hdead),
                32'(k < exp_q.size() ? exp_q[k] : 16'hbeef));
        exp_q.delete();
        chk("stream_empty", 32'(empty_o), 32'd1);

        // Clear during SHIFT of word 1, then a full fresh frame
        rand_data();
        do_start();
        repeat (TCONV + WORDLEN * 2 * SCKDIV + NCH + TSW + 20) tick();
        chk("mid_busy_before", 32'(busy_o), 32'd1);
        do_clr("clr_mid");
        adc_d[0][0] = tbl[0].l0i; adc_d[1][0] = tbl[0].l0q;
        adc_d[0][1] = tbl[0].l1i; adc_d[1][1] = tbl[0].l1q;
        do_start();
        wait_done("after_clr");
        drain("after_clr");

        // Randomised bursts of frames against the model
        for (int r = 0; r < 8; r++) begin
            int ns;
            ns = int'($urandom_range(1, 5));
            for (int s = 0; s < ns; s++) begin
                rand_data();
                do_start();
                wait_done("rnd");
            end
            drain("rnd");
            chk("rnd_ovf_hold", 32'(ovf_o), 32'(ovf_m));
            do_clr("rnd_clr");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
